// File: rtl/spi_flash_sequencer.sv
// ============================================================================
// Module      : spi_flash_sequencer
// Description : Sequences a SPI flash READ: loads command+address into the TX
//               buffer, runs the command and data phases, reports completion.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module spi_flash_sequencer #(
    parameter logic [7:0] READ_CMD = 8'h03,
    parameter int         TIMEOUT  = 65535
) (
    input  logic        FastClk,
    input  logic        Reset,
    input  logic        Start,
    input  logic        Abort,
    input  logic [23:0] Addr,
    input  logic [8:0]  Len,
    output logic        Busy,
    output logic        Done,
    output logic        Error,
    output logic        SpiStart,
    output logic [1:0]  SpiMode,
    output logic [8:0]  SpiLen,
    output logic        SpiCsLow,
    input  logic        SpiBusy,
    output logic        TxWe,
    output logic [8:0]  TxAddr,
    output logic [7:0]  TxData
);

    localparam int              TW         = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0]   C_TMO_LAST = TW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_CMD   = 3'd2,
        S_WAITC = 3'd3,
        S_DATA  = 3'd4,
        S_WAITD = 3'd5,
        S_FIN   = 3'd6
    } state_t;

    state_t          r_state;
    logic [23:0]     r_addr;
    logic [8:0]      r_len;
    logic [1:0]      r_byte;
    logic [TW-1:0]   r_tmo;
    logic            r_busy;
    logic            r_done;
    logic            r_error;
    logic            r_spi_start;
    logic [1:0]      r_spi_mode;
    logic [8:0]      r_spi_len;
    logic            r_cs;
    logic            r_tx_we;
    logic [8:0]      r_tx_addr;
    logic [7:0]      r_tx_data;

    always_ff @(posedge FastClk) begin
        if (Reset) begin
            r_state     <= S_IDLE;
            r_addr      <= '0;
            r_len       <= '0;
            r_byte      <= '0;
            r_tmo       <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_error     <= 1'b0;
            r_spi_start <= 1'b0;
            r_spi_mode  <= '0;
            r_spi_len   <= '0;
            r_cs        <= 1'b0;
            r_tx_we     <= 1'b0;
            r_tx_addr   <= '0;
            r_tx_data   <= '0;
        end else begin
            // Pulses and per-transfer fields default low every cycle.
            r_done      <= 1'b0;
            r_spi_start <= 1'b0;
            r_spi_mode  <= '0;
            r_spi_len   <= '0;
            r_tx_we     <= 1'b0;
            r_tx_addr   <= '0;
            r_tx_data   <= '0;

            if (Abort && r_state != S_IDLE && r_state != S_FIN) begin
                r_state <= S_FIN;
                r_cs    <= 1'b0;
                r_done  <= 1'b1;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (Start) begin
                            r_addr    <= Addr;
                            r_len     <= Len;
                            r_error   <= 1'b0;
                            r_busy    <= 1'b1;
                            r_cs      <= 1'b1;
                            r_byte    <= 2'd0;
                            r_tx_we   <= 1'b1;
                            r_tx_addr <= 9'd0;
                            r_tx_data <= READ_CMD;
                            r_state   <= S_LOAD;
                        end
                    end
                    S_LOAD: begin
                        if (r_byte == 2'd3) begin
                            r_spi_start <= 1'b1;
                            r_spi_mode  <= 2'd1;
                            r_spi_len   <= 9'd3;
                            r_state     <= S_CMD;
                        end else begin
                            r_byte    <= r_byte + 2'd1;
                            r_tx_we   <= 1'b1;
                            r_tx_addr <= {7'd0, r_byte} + 9'd1;
                            case (r_byte)
                                2'd0:    r_tx_data <= r_addr[23:16];
                                2'd1:    r_tx_data <= r_addr[15:8];
                                default: r_tx_data <= r_addr[7:0];
                            endcase
                        end
                    end
                    S_CMD: begin
                        r_tmo   <= '0;
                        r_state <= S_WAITC;
                    end
                    S_WAITC, S_WAITD: begin
                        // r_tmo==0 is the cycle right after SpiStart; the engine
                        // may not have raised SpiBusy yet.
                        if (r_tmo != '0 && !SpiBusy) begin
                            if (r_state == S_WAITC) begin
                                r_spi_start <= 1'b1;
                                r_spi_mode  <= 2'd3;
                                r_spi_len   <= r_len - 9'd1;
                                r_state     <= S_DATA;
                            end else begin
                                r_cs    <= 1'b0;
                                r_done  <= 1'b1;
                                r_state <= S_FIN;
                            end
                        end else if (r_tmo == C_TMO_LAST) begin
                            r_error <= 1'b1;
                            r_cs    <= 1'b0;
                            r_done  <= 1'b1;
                            r_state <= S_FIN;
                        end else begin
                            r_tmo <= r_tmo + 1'b1;
                        end
                    end
                    S_DATA: begin
                        r_tmo   <= '0;
                        r_state <= S_WAITD;
                    end
                    S_FIN: begin
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                    default: begin
                        r_busy  <= 1'b0;
                        r_cs    <= 1'b0;
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign Busy     = r_busy;
    assign Done     = r_done;
    assign Error    = r_error;
    assign SpiStart = r_spi_start;
    assign SpiMode  = r_spi_mode;
    assign SpiLen   = r_spi_len;
    assign SpiCsLow = r_cs;
    assign TxWe     = r_tx_we;
    assign TxAddr   = r_tx_addr;
    assign TxData   = r_tx_data;

endmodule

`default_nettype wire

// File: tb/tb_spi_flash_sequencer.sv
// ============================================================================
// Module      : tb_spi_flash_sequencer
// Description : Randomized bench for spi_flash_sequencer against a schedule model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_spi_flash_sequencer;

    localparam int NM   = 160;
    localparam int TMO0 = 24;
    localparam int TMO1 = 16;

    localparam int P_IDLE = 0, P_LOAD = 1, P_CMD = 2, P_WC = 3,
                   P_DATA = 4, P_WD = 5, P_FIN = 6;

    logic        FastClk = 1'b0;
    logic        Reset, Start, Abort, SpiBusy;
    logic [23:0] Addr;
    logic [8:0]  Len;

    logic        Busy_o[2], Done_o[2], Error_o[2], SpiStart_o[2], SpiCsLow_o[2], TxWe_o[2];
    logic [1:0]  SpiMode_o[2];
    logic [8:0]  SpiLen_o[2], TxAddr_o[2];
    logic [7:0]  TxData_o[2];

    always #5 FastClk = ~FastClk;

    spi_flash_sequencer #(.READ_CMD(8'h03), .TIMEOUT(TMO0)) u_dut0 (
        .FastClk(FastClk), .Reset(Reset), .Start(Start), .Abort(Abort),
        .Addr(Addr), .Len(Len), .Busy(Busy_o[0]), .Done(Done_o[0]), .Error(Error_o[0]),
        .SpiStart(SpiStart_o[0]), .SpiMode(SpiMode_o[0]), .SpiLen(SpiLen_o[0]),
        .SpiCsLow(SpiCsLow_o[0]), .SpiBusy(SpiBusy), .TxWe(TxWe_o[0]),
        .TxAddr(TxAddr_o[0]), .TxData(TxData_o[0])
    );

    spi_flash_sequencer #(.READ_CMD(8'h0B), .TIMEOUT(TMO1)) u_dut1 (
        .FastClk(FastClk), .Reset(Reset), .Start(Start), .Abort(Abort),
        .Addr(Addr), .Len(Len), .Busy(Busy_o[1]), .Done(Done_o[1]), .Error(Error_o[1]),
        .SpiStart(SpiStart_o[1]), .SpiMode(SpiMode_o[1]), .SpiLen(SpiLen_o[1]),
        .SpiCsLow(SpiCsLow_o[1]), .SpiBusy(SpiBusy), .TxWe(TxWe_o[1]),
        .TxAddr(TxAddr_o[1]), .TxData(TxData_o[1])
    );

    int checks = 0;
    int errors = 0;

    // Per-transaction stimulus tables and expected phase timelines.
    bit          bz[NM];
    bit          stv[NM];
    bit          abv[NM];
    bit          rsv[NM];
    int          ph[2][NM];
    bit          erv[2][NM];
    int          fin_k[2];
    logic [23:0] t_addr;
    logic [8:0]  t_len;

    int          n_ss[2], n_done[2], n_cs[2], done_k[2], data_k[2], nw[2];
    logic [8:0]  last_len[2];
    bit          err_done[2];
    logic [7:0]  wd[2][8];
    logic [8:0]  wa[2][8];
    logic [33:0] obs_kr[2];

    function automatic logic [7:0] cmdb(input int i);
        return (i == 0) ? 8'h03 : 8'h0B;
    endfunction

    task automatic lit(input string nm, input longint got, input longint exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d", nm, got, exp);
        end
    endtask

    task automatic place(input int s, input int dur, input bit stuck);
        for (int k = s; k < NM; k++)
            if (stuck || k < s + dur) bz[k] = 1'b1;
    endtask

    // A wait entered at out-cycle ws ends at the first later cycle whose busy
    // sample is low (the sample right after SpiStart is ignored), or after tmo cycles.
    task automatic resolve(input int ws, input int tmo, output int nxt, output bit to);
        nxt = ws + tmo;
        to  = 1'b1;
        for (int j = 1; j < tmo; j++) begin
            if (!bz[ws + 1 + j]) begin
                nxt = ws + 1 + j;
                to  = 1'b0;
                break;
            end
        end
    endtask

    task automatic build(input int i, input int tmo, input int ka, input int kr);
        int n, m, f;
        bit t, t2;
        for (int k = 0; k < NM; k++) begin
            ph[i][k]  = P_IDLE;
            erv[i][k] = 1'b0;
        end
        for (int k = 1; k <= 4; k++) ph[i][k] = P_LOAD;
        ph[i][5] = P_CMD;
        resolve(6, tmo, n, t);
        for (int k = 6; k < n; k++) ph[i][k] = P_WC;
        if (t) begin
            f = n;
        end else begin
            ph[i][n] = P_DATA;
            resolve(n + 1, tmo, m, t2);
            for (int k = n + 1; k < m; k++) ph[i][k] = P_WD;
            f = m;
            t = t2;
        end
        ph[i][f] = P_FIN;
        if (ka >= 2 && ka < NM && ph[i][ka-1] >= P_LOAD && ph[i][ka-1] <= P_WD) begin
            for (int k = ka + 1; k <= f; k++) ph[i][k] = P_IDLE;
            ph[i][ka] = P_FIN;
            f = ka;
            t = 1'b0;
        end
        if (t) for (int k = f; k < NM; k++) erv[i][k] = 1'b1;
        if (kr > 0) begin
            for (int k = kr; k < NM; k++) begin
                ph[i][k]  = P_IDLE;
                erv[i][k] = 1'b0;
            end
        end
        fin_k[i] = f;
    endtask

    function automatic logic [33:0] expv(input int i, input int k);
        int p, cnt;
        logic ss, cs, we;
        logic [1:0] md;
        logic [8:0] sl, ta;
        logic [7:0] td;
        p   = ph[i][k];
        cnt = (t_len == 9'd0) ? 512 : int'(t_len);
        ss  = (p == P_CMD) || (p == P_DATA);
        md  = (p == P_CMD) ? 2'd1 : (p == P_DATA) ? 2'd3 : 2'd0;
        sl  = (p == P_CMD) ? 9'd3 : (p == P_DATA) ? 9'(cnt - 1) : 9'd0;
        cs  = (p >= P_LOAD) && (p <= P_WD);
        we  = (p == P_LOAD);
        ta  = we ? 9'(k - 1) : 9'd0;
        td  = 8'd0;
        if (we) begin
            case (k)
                1:       td = cmdb(i);
                2:       td = t_addr[23:16];
                3:       td = t_addr[15:8];
                default: td = t_addr[7:0];
            endcase
        end
        return {p != P_IDLE, p == P_FIN, erv[i][k], ss, md, sl, cs, we, ta, td};
    endfunction

    function automatic logic [33:0] obsv(input int i);
        return {Busy_o[i], Done_o[i], Error_o[i], SpiStart_o[i], SpiMode_o[i], SpiLen_o[i],
                SpiCsLow_o[i], TxWe_o[i], TxAddr_o[i], TxData_o[i]};
    endfunction

    task automatic run_txn(input logic [23:0] a, input logic [8:0] ln,
                           input bit cl, input int cd, input bit cst,
                           input bit dl, input int dd, input bit dst,
                           input int ka, input int kst, input int kr, input int gap);
        int n, nt;
        bit to;
        logic [33:0] ov, ev;
        t_addr = a;
        t_len  = ln;
        for (int k = 0; k < NM; k++) begin
            bz[k] = 1'b0; stv[k] = 1'b0; abv[k] = 1'b0; rsv[k] = 1'b0;
        end
        stv[1] = 1'b1;
        place(7 + int'(cl), cd, cst);
        resolve(6, TMO0, n, to);
        if (!to) place(n + 2 + int'(dl), dd, dst);
        if (ka > 0 && ka < NM) abv[ka] = 1'b1;
        if (kr > 0 && kr < NM) rsv[kr] = 1'b1;
        build(0, TMO0, ka, kr);
        build(1, TMO1, ka, kr);
        nt = (kr > 0) ? kr + 1 : ((fin_k[0] > fin_k[1]) ? fin_k[0] : fin_k[1]) + 2 + gap;
        if (nt > NM - 1) nt = NM - 1;
        if (kst > 1 && kst <= nt &&
            ((ph[0][kst-1] != P_IDLE && ph[1][kst-1] != P_IDLE) || rsv[kst]))
            stv[kst] = 1'b1;
        for (int k = 2; k <= nt; k++)
            if (ph[0][k-1] == P_IDLE && ph[1][k-1] == P_IDLE && !stv[k] && $urandom_range(0, 1) == 1)
                abv[k] = 1'b1;
        for (int i = 0; i < 2; i++) begin
            n_ss[i] = 0; n_done[i] = 0; n_cs[i] = 0; done_k[i] = 0; data_k[i] = 0; nw[i] = 0;
            last_len[i] = '0; err_done[i] = 1'b0; obs_kr[i] = '1;
        end
        for (int k = 1; k <= nt; k++) begin
            Start   = stv[k];
            Abort   = abv[k];
            Reset   = rsv[k];
            SpiBusy = bz[k];
            Addr    = (k == 1) ? a : 24'($urandom);
            Len     = (k == 1) ? ln : 9'($urandom);
            @(posedge FastClk);
            #1;
            for (int i = 0; i < 2; i++) begin
                ov = obsv(i);
                ev = expv(i, k);
                checks++;
                if (ov !== ev) begin
                    errors++;
                    $display("FAIL cycle k=%0d inst=%0d got=%h exp=%h", k, i, ov, ev);
                end
                if (SpiStart_o[i]) begin
                    n_ss[i]++;
                    if (SpiMode_o[i] == 2'd3) begin
                        last_len[i] = SpiLen_o[i];
                        data_k[i]   = k;
                    end
                end
                if (Done_o[i]) begin
                    n_done[i]++;
                    done_k[i]   = k;
                    err_done[i] = Error_o[i];
                end
                if (SpiCsLow_o[i]) n_cs[i]++;
                if (TxWe_o[i]) begin
                    if (nw[i] < 8) begin
                        wa[i][nw[i]] = TxAddr_o[i];
                        wd[i][nw[i]] = TxData_o[i];
                    end
                    nw[i]++;
                end
                if (k == kr) obs_kr[i] = ov;
            end
        end
        Start = 1'b0; Abort = 1'b0; Reset = 1'b0; SpiBusy = 1'b0;
    endtask

    initial begin
        Reset = 1'b1; Start = 1'b1; Abort = 1'b1; SpiBusy = 1'b0;
        Addr = 24'h0; Len = 9'd0;
        repeat (3) @(posedge FastClk);
        #1;
        lit("reset_state0", longint'(obsv(0)), 0);
        lit("reset_state1", longint'(obsv(1)), 0);
        Reset = 1'b0; Start = 1'b0; Abort = 1'b0;
        @(posedge FastClk);
        #1;

        // Nominal read, 20-cycle busy in each phase.
        run_txn(24'h123456, 9'd4, 0, 20, 0, 0, 20, 0, 0, 0, 0, 1);
        lit("model_fin0", fin_k[0], 49);
        lit("model_fin1", fin_k[1], 22);
        lit("nom_nw", nw[0], 4);
        lit("nom_d0", wd[0][0], 8'h03);
        lit("nom_d1", wd[0][1], 8'h12);
        lit("nom_d2", wd[0][2], 8'h34);
        lit("nom_d3", wd[0][3], 8'h56);
        lit("nom_a3", wa[0][3], 3);
        lit("nom_cmd1", wd[1][0], 8'h0B);
        lit("nom_ss", n_ss[0], 2);
        lit("nom_len", last_len[0], 3);
        lit("nom_done", n_done[0], 1);
        lit("nom_err", err_done[0], 0);
        lit("nom_cs", n_cs[0], 48);
        lit("nom_tmo_k", done_k[1], 22);
        lit("nom_tmo_err", err_done[1], 1);
        lit("nom_tmo_ss", n_ss[1], 1);

        run_txn(24'($urandom), 9'd0, 0, 3, 0, 0, 3, 0, 0, 0, 0, 0);
        lit("len0_spilen", last_len[0], 511);
        run_txn(24'($urandom), 9'd1, 0, 3, 0, 0, 3, 0, 0, 0, 0, 0);
        lit("len1_spilen", last_len[0], 0);

        // SpiBusy stuck high.
        run_txn(24'($urandom), 9'd8, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0);
        lit("stuck_k16", done_k[1], 22);
        lit("stuck_err16", err_done[1], 1);
        lit("stuck_ss16", n_ss[1], 1);
        lit("stuck_cs16", n_cs[1], 21);
        lit("stuck_k24", done_k[0], 30);

        run_txn(24'($urandom), 9'd16, 0, 5, 0, 0, 10, 0, 16, 0, 0, 0);
        lit("abort_k", done_k[0], 16);
        lit("abort_err", err_done[0], 0);
        lit("abort_done", n_done[0], 1);

        run_txn(24'($urandom), 9'd16, 0, 5, 0, 0, 10, 0, 0, 18, 0, 0);
        lit("restart_ss0", n_ss[0], 2);
        lit("restart_ss1", n_ss[1], 2);
        lit("restart_k", done_k[0], 24);

        run_txn(24'hABCDEF, 9'd5, 0, 4, 0, 0, 4, 0, 0, 0, 3, 0);
        lit("rst_zero0", longint'(obs_kr[0]), 0);
        lit("rst_zero1", longint'(obs_kr[1]), 0);
        lit("rst_nw", nw[0], 2);
        run_txn(24'h00C0DE, 9'd2, 0, 2, 0, 0, 2, 0, 0, 0, 0, 0);
        lit("post_rst_nw", nw[0], 4);
        lit("post_rst_d2", wd[0][2], 8'hC0);
        lit("post_rst_d3", wd[0][3], 8'hDE);

        // Busy rises one cycle late in both phases.
        run_txn(24'($urandom), 9'd3, 1, 6, 0, 1, 6, 0, 0, 0, 0, 0);
        lit("late_data_k", data_k[0], 14);
        lit("late_done_k", done_k[0], 23);

        for (int r = 0; r < 150; r++) begin
            run_txn(24'($urandom), 9'($urandom),
                    1'($urandom_range(0, 1)), $urandom_range(1, 30), ($urandom_range(0, 15) == 0),
                    1'($urandom_range(0, 1)), $urandom_range(1, 30), ($urandom_range(0, 15) == 0),
                    ($urandom_range(0, 3) == 0) ? $urandom_range(2, 60) : 0,
                    ($urandom_range(0, 2) == 0) ? $urandom_range(2, 60) : 0,
                    ($urandom_range(0, 9) == 0) ? $urandom_range(2, 50) : 0,
                    $urandom_range(0, 3));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
